// File: rtl/tt_scan_ctrl.sv
// Exhaustive truth-table sweeper: drives every input vector of a small combinational
// block, samples its outputs after a settle time and grades them against an expected table.
module tt_scan_ctrl #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [N_OUT*(2**N_IN)-1:0]   exp_tt,
    output logic [N_IN-1:0]              dut_in,
    input  logic [N_OUT-1:0]             dut_out,
    output logic [N_OUT*(2**N_IN)-1:0]   tt,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN:0]                mismatch_cnt,
    output logic [N_IN-1:0]              fail_idx,
    output logic                         fail_vld
);

    localparam int ROWS  = 2 ** N_IN;
    localparam int IDX_W = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1;
    localparam int CNT_W = ($clog2(SETTLE) > 0) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_FINISH
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_IN-1:0]     dut_in_q;
    logic [N_OUT-1:0]    tt_rows_q [ROWS];
    logic [N_IN:0]       mismatch_q;
    logic [N_IN-1:0]     fail_idx_q;
    logic                fail_vld_q;
    logic                pass_q;
    logic                busy_q;
    logic                done_q;

    logic [N_OUT-1:0]    exp_rows [ROWS];
    logic [N_OUT-1:0]    exp_row;
    logic                row_miss;
    logic                last_row;

    // Flat tables are viewed row-by-row so the sampler can index them by idx_q.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_rows
            assign exp_rows[gi]                = exp_tt[gi*N_OUT +: N_OUT];
            assign tt[gi*N_OUT +: N_OUT]       = tt_rows_q[gi];
        end
    endgenerate

    assign exp_row  = exp_rows[idx_q];
    assign row_miss = (dut_out != exp_row);
    assign last_row = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            dut_in_q   <= '0;
            mismatch_q <= '0;
            fail_idx_q <= '0;
            fail_vld_q <= 1'b0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                tt_rows_q[r] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= S_SETTLE;
                        busy_q     <= 1'b1;
                        idx_q      <= '0;
                        dut_in_q   <= '0;
                        cnt_q      <= CNT_RELOAD;
                        mismatch_q <= '0;
                        fail_vld_q <= 1'b0;
                        pass_q     <= 1'b0;
                        for (int r = 0; r < ROWS; r++) begin
                            tt_rows_q[r] <= '0;
                        end
                    end
                end

                S_SETTLE: begin
                    if (abort) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        dut_in_q <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        tt_rows_q[idx_q] <= dut_out;
                        if (row_miss) begin
                            mismatch_q <= mismatch_q + 1'b1;
                            if (!fail_vld_q) begin
                                fail_idx_q <= N_IN'(idx_q);
                                fail_vld_q <= 1'b1;
                            end
                        end
                        if (last_row) begin
                            state_q  <= S_FINISH;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            dut_in_q <= '0;
                            // Folds in the final row so pass is already valid while done is high.
                            pass_q   <= (mismatch_q == '0) && !row_miss;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            dut_in_q <= N_IN'(idx_q + 1'b1);
                            cnt_q    <= CNT_RELOAD;
                        end
                    end
                end

                S_FINISH: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in       = dut_in_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mismatch_q;
    assign fail_idx     = fail_idx_q;
    assign fail_vld     = fail_vld_q;

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Bench for tt_scan_ctrl: two instances (settle 1 and 3) sweeping a table-driven
// function model, checked against hand-written vectors and a randomized reference model.
module tb_tt_scan_ctrl;

    localparam int ROWS = 8;

    typedef struct {
        int          sel;
        logic [15:0] func;
        logic [15:0] exp;
        int          abort_at;
        int          restart_at;
        logic [15:0] e_tt;
        int          e_cnt;
        int          e_fidx;
        bit          e_vld;
        bit          e_pass;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic [15:0] func_a, func_b, exp_a, exp_b;
    logic [2:0]  dut_in_a, dut_in_b;
    logic [1:0]  dut_out_a, dut_out_b;
    logic [15:0] tt_a, tt_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [3:0]  mcnt_a, mcnt_b;
    logic [2:0]  fidx_a, fidx_b;
    logic        fvld_a, fvld_b;

    // The function under test is a lookup into a bench-owned truth table.
    assign dut_out_a = func_a[{dut_in_a, 1'b0} +: 2];
    assign dut_out_b = func_b[{dut_in_b, 1'b0} +: 2];

    tt_scan_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .exp_tt(exp_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .tt(tt_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .mismatch_cnt(mcnt_a), .fail_idx(fidx_a), .fail_vld(fvld_a)
    );

    tt_scan_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .exp_tt(exp_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .tt(tt_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .mismatch_cnt(mcnt_b), .fail_idx(fidx_b), .fail_vld(fvld_b)
    );

    int          sel;
    logic [2:0]  v_dut_in, v_fidx;
    logic [15:0] v_tt;
    logic [3:0]  v_mcnt;
    logic        v_busy, v_done, v_pass, v_fvld;

    always_comb begin
        v_dut_in = dut_in_a;
        v_tt     = tt_a;
        v_mcnt   = mcnt_a;
        v_fidx   = fidx_a;
        v_busy   = busy_a;
        v_done   = done_a;
        v_pass   = pass_a;
        v_fvld   = fvld_a;
        if (sel != 0) begin
            v_dut_in = dut_in_b;
            v_tt     = tt_b;
            v_mcnt   = mcnt_b;
            v_fidx   = fidx_b;
            v_busy   = busy_b;
            v_done   = done_b;
            v_pass   = pass_b;
            v_fvld   = fvld_b;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic set_start(input logic b);
        if (sel == 0) start_a = b; else start_b = b;
    endtask

    task automatic set_abort(input logic b);
        if (sel == 0) abort_a = b; else abort_b = b;
    endtask

    // Reference: the table is simply every sampled row of the function, graded row by row.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          s;
        int          nrows;
        logic [1:0]  row;
        logic [1:0]  er;
        r      = v;
        s      = (v.sel == 0) ? 1 : 3;
        nrows  = (v.abort_at < 0) ? ROWS : v.abort_at / s;
        r.e_tt = '0; r.e_cnt = 0; r.e_fidx = 0; r.e_vld = 1'b0;
        for (int k = 0; k < nrows; k++) begin
            row = v.func[k*2 +: 2];
            er  = v.exp[k*2 +: 2];
            r.e_tt[k*2 +: 2] = row;
            if (row != er) begin
                r.e_cnt++;
                if (!r.e_vld) begin
                    r.e_vld  = 1'b1;
                    r.e_fidx = k;
                end
            end
        end
        r.e_pass = (v.abort_at < 0) && (r.e_cnt == 0);
        return r;
    endfunction

    task automatic scan(input vec_t v, input string name);
        int s;
        int total;
        int errs;
        int done_seen;
        bit aborted;
        s = (v.sel == 0) ? 1 : 3;
        total = ROWS * s;
        errs = 0;
        done_seen = 0;
        aborted = 1'b0;
        sel = v.sel;
        @(negedge clk);
        if (sel == 0) begin func_a = v.func; exp_a = v.exp; end
        else          begin func_b = v.func; exp_b = v.exp; end
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int j = 0; j < total; j++) begin
            if (j > 0) @(negedge clk);
            if (v_dut_in !== 3'(j / s) || v_busy !== 1'b1 || v_done !== 1'b0) errs++;
            if (v.restart_at == j || (v.restart_at == -2 && $urandom_range(0, 3) == 0))
                set_start(1'b1);
            else
                set_start(1'b0);
            if (j == v.abort_at) begin
                set_abort(1'b1);
                aborted = 1'b1;
                break;
            end
        end
        @(negedge clk);
        set_start(1'b0);
        set_abort(1'b0);
        check({name, ".sequence_errs"}, errs, 0);
        check({name, ".busy_end"}, v_busy, 0);
        check({name, ".dut_in_end"}, v_dut_in, 0);
        check({name, ".done"}, v_done, aborted ? 0 : 1);
        check({name, ".tt"}, v_tt, v.e_tt);
        check({name, ".mismatch_cnt"}, v_mcnt, v.e_cnt);
        check({name, ".fail_vld"}, v_fvld, v.e_vld);
        if (v.e_vld) check({name, ".fail_idx"}, v_fidx, v.e_fidx);
        check({name, ".pass"}, v_pass, v.e_pass);
        @(negedge clk);
        check({name, ".done_one_cycle"}, v_done, 0);
        check({name, ".pass_hold"}, v_pass, v.e_pass);
        if (aborted) begin
            repeat (total) begin
                @(negedge clk);
                if (v_done !== 1'b0) done_seen++;
            end
            check({name, ".no_done_after_abort"}, done_seen, 0);
        end
        $display("scan %s sel=%0d func=%h exp=%h abort_at=%0d -> tt=%h cnt=%0d vld=%0b idx=%0d pass=%0b",
                 name, v.sel, v.func, v.exp, v.abort_at, v_tt, v_mcnt, v_fvld, v_fidx, v_pass);
    endtask

    vec_t tbl [7];

    initial begin
        vec_t rv;
        int   s;
        rst_n = 1'b0;
        start_a = 1'b1; start_b = 1'b1; abort_a = 1'b0; abort_b = 1'b0;
        func_a = 16'hFF0A; func_b = 16'hFF0A; exp_a = 16'hFF0A; exp_b = 16'hFF0A;
        sel = 0;

        tbl[0] = '{0, 16'hFF0A, 16'hFF0A, -1, -1, 16'hFF0A, 0, 0, 1'b0, 1'b1};
        tbl[1] = '{0, 16'hFF0A, 16'h7F0B, -1, -1, 16'hFF0A, 2, 0, 1'b1, 1'b0};
        tbl[2] = '{0, 16'hFF0A, 16'h7F0A, -1, -1, 16'hFF0A, 1, 7, 1'b1, 1'b0};
        tbl[3] = '{1, 16'hFF0A, 16'hFF0A, -1, -1, 16'hFF0A, 0, 0, 1'b0, 1'b1};
        tbl[4] = '{0, 16'hFF0A, 16'hFFCA,  3,  2, 16'h000A, 0, 0, 1'b0, 1'b0};
        tbl[5] = '{1, 16'hFF0A, 16'h7F0B, -1,  5, 16'hFF0A, 2, 0, 1'b1, 1'b0};
        tbl[6] = '{1, 16'hFF0A, 16'hFF0B, 10, -1, 16'h000A, 1, 0, 1'b1, 1'b0};

        // Reset held with start high and a changing function output.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            func_a = 16'($urandom); func_b = 16'($urandom);
            check("reset.a_flags", {busy_a, done_a, pass_a, fvld_a}, 0);
            check("reset.a_data", {tt_a, mcnt_a, fidx_a, dut_in_a}, 0);
            check("reset.b_flags", {busy_b, done_b, pass_b, fvld_b}, 0);
            check("reset.b_data", {tt_b, mcnt_b, fidx_b, dut_in_b}, 0);
        end
        start_a = 1'b0; start_b = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_reset.idle", {busy_a, done_a, busy_b, done_b}, 0);

        for (int i = 0; i < 7; i++) scan(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            rv.sel  = int'($urandom_range(0, 1));
            s       = (rv.sel == 0) ? 1 : 3;
            rv.func = 16'($urandom);
            rv.exp  = ($urandom_range(0, 2) == 0) ? rv.func : (rv.func ^ 16'($urandom & $urandom));
            rv.abort_at   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ROWS * s - 1)) : -1;
            rv.restart_at = -2;
            rv = model(rv);
            scan(rv, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a scan.
        sel = 0;
        @(negedge clk);
        func_a = 16'hFF0A; exp_a = 16'h7F0B; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        check("async.pre_dut_in", dut_in_a, 5);
        check("async.pre_mcnt", mcnt_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async.dut_in", dut_in_a, 0);
        check("async.tt", tt_a, 0);
        check("async.flags", {busy_a, done_a, pass_a, fvld_a}, 0);
        check("async.mcnt", mcnt_a, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("async.idle", {busy_a, done_a, dut_in_a}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
